// File: rtl/strobe_interval_arbiter.sv
// strobe_interval_arbiter
//
// Time-shares one interval down-counter between CHANNELS requesters. Each
// channel posts an interval; a round-robin arbiter hands the counter to one
// pending channel at a time. Once the owner's interval has elapsed in enabled
// ticks, a one-cycle done pulse is returned to that channel.
//
// Ports:
//   clk           single clock, all logic on posedge
//   rst           asynchronous active-low reset
//   enable        tick qualifier; the counter only advances when high
//   req_valid     per-channel request
//   req_interval  packed intervals, channel i at [i*WIDTH +: WIDTH]
//   req_ready     channel may post (not pending and not current owner)
//   abort         cancel the pending or active request of a channel
//   done          one-cycle completion pulse per channel
//   busy          counter currently owned
//   active_ch     owning channel while busy, 0 otherwise
module strobe_interval_arbiter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 25,
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       req_valid,
  input  logic [CHANNELS*WIDTH-1:0] req_interval,
  output logic [CHANNELS-1:0]       req_ready,
  input  logic [CHANNELS-1:0]       abort,
  output logic [CHANNELS-1:0]       done,
  output logic                      busy,
  output logic [IDX_W-1:0]          active_ch
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  logic                state_q, state_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [WIDTH-1:0]    interval_q [CHANNELS];
  logic [WIDTH-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    active_q, active_d;
  logic [CHANNELS-1:0] done_q, done_d;

  logic [CHANNELS-1:0] owner;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] eligible;
  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  int unsigned         idx_c;

  // One-hot of the channel currently holding the counter.
  always_comb begin
    owner = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      owner[i] = (state_q == ST_COUNT) && (active_q == IDX_W'(i));
    end
  end

  assign req_ready = ~pending_q & ~owner;
  // Abort wins over a same-cycle post: the request is dropped.
  assign accept    = req_valid & req_ready & ~abort;

  // Round-robin search starting at rr_q; an abort in the arbitration cycle
  // removes the channel from contention.
  always_comb begin
    eligible    = pending_q & ~abort;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_c       = 0;
    for (int off = 0; off < CHANNELS; off++) begin
      idx_c = (int'(rr_q) + off) % CHANNELS;
      if (!grant_found && eligible[idx_c]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(idx_c);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rr_d      = rr_q;
    active_d  = active_q;
    done_d    = '0;
    pending_d = (pending_q & ~abort) | accept;

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d              = ST_COUNT;
          active_d             = grant_idx;
          count_d              = interval_q[grant_idx];
          pending_d[grant_idx] = 1'b0;
          rr_d = (grant_idx == IDX_W'(CHANNELS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
      end
      default: begin
        if (|(abort & owner)) begin
          // Aborted owner: release the counter silently.
          state_d  = ST_IDLE;
          count_d  = '0;
          active_d = '0;
        end else if (enable) begin
          count_d = count_q - WIDTH'(1);
          if (count_q == WIDTH'(1)) begin
            state_d  = ST_IDLE;
            done_d   = owner;
            active_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
      rr_q      <= '0;
      active_q  <= '0;
      done_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        interval_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      rr_q      <= rr_d;
      active_q  <= active_d;
      done_q    <= done_d;
      for (int i = 0; i < CHANNELS; i++) begin
        if (accept[i]) begin
          // A zero interval would never reach the count==1 terminal value.
          interval_q[i] <= (req_interval[i*WIDTH +: WIDTH] == '0) ? WIDTH'(1)
                                                                   : req_interval[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign done      = done_q;
  assign busy      = (state_q == ST_COUNT);
  assign active_ch = active_q;

endmodule

// File: tb/tb_strobe_interval_arbiter.sv
module tb_strobe_interval_arbiter;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b1;
  logic [CH-1:0]   req_valid = '0;
  logic [CH*W-1:0] req_interval = '0;
  logic [CH-1:0]   req_ready;
  logic [CH-1:0]   abort = '0;
  logic [CH-1:0]   done;
  logic            busy;
  logic [1:0]      active_ch;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  strobe_interval_arbiter #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_interval(req_interval),
    .req_ready   (req_ready),
    .abort       (abort),
    .done        (done),
    .busy        (busy),
    .active_ch   (active_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int ch, input int at);
    exp_t e;
    e.ch  = ch;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    req_valid = '0;
    abort = '0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 4'b0 || busy !== 1'b0 || active_ch !== 2'd0 || req_ready !== 4'hF) begin
      failures++;
      $display("FAIL reset_hold: done=%b busy=%b act=%0d ready=%b, expected 0000 0 0 1111",
               done, busy, active_ch, req_ready);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 4'b0 || busy !== 1'b0 || req_ready !== 4'hF) begin
      failures++;
      $display("FAIL reset_release: done=%b busy=%b ready=%b, expected 0000 0 1111",
               done, busy, req_ready);
    end
  endtask

  task automatic test_single;
    exp_t e;
    int   acc;
    apply_reset();
    req_interval[1*W +: W] = 8'd5;
    req_valid = 4'b0010;
    acc = cyc + 1;
    push_exp(1, acc + 6);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (req_ready[1] !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_pending: ready1=%b busy=%b, expected 0 0", req_ready[1], busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || active_ch !== 2'd1 || req_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: busy=%b act=%0d ready1=%b, expected 1 1 0",
               busy, active_ch, req_ready[1]);
    end
    for (int t = 0; t < 30 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++;
        if (done !== (4'b0001 << e.ch) || cyc != e.cyc || req_ready[1] !== 1'b1) begin
          failures++;
          $display("FAIL single_done: done=%b cyc=%0d ready1=%b, expected ch%0d at %0d ready1=1",
                   done, cyc, req_ready[1], e.ch, e.cyc);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL single_timeout: missing=%0d, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse_width: done=%b busy=%b, expected 0000 0", done, busy);
    end
  endtask

  task automatic test_all_channels;
    exp_t e;
    int   acc;
    apply_reset();
    req_interval = {8'd3, 8'd3, 8'd3, 8'd3};
    req_valid = 4'hF;
    acc = cyc + 1;
    for (int k = 0; k < CH; k++) push_exp(k, acc + 4 + 4 * k);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (req_ready !== 4'h0) begin
      failures++;
      $display("FAIL all_pending: ready=%b, expected 0000", req_ready);
    end
    for (int t = 0; t < 60 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++;
        if (done !== (4'b0001 << e.ch) || cyc != e.cyc) begin
          failures++;
          $display("FAIL all_order: done=%b cyc=%0d, expected ch%0d at %0d",
                   done, cyc, e.ch, e.cyc);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL all_timeout: missing=%0d, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_enable_toggle;
    exp_t e;
    int   acc;
    apply_reset();
    req_interval[2*W +: W] = 8'd4;
    req_valid = 4'b0100;
    acc = cyc + 1;
    // COUNT cycles run with enable 0,1,0,1,...: the 4th enabled one is the 8th.
    push_exp(2, acc + 9);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || active_ch !== 2'd2) begin
      failures++;
      $display("FAIL toggle_grant: busy=%b act=%0d, expected 1 2", busy, active_ch);
    end
    enable = 1'b0;
    for (int t = 0; t < 30 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++;
        if (done !== (4'b0001 << e.ch) || cyc != e.cyc) begin
          failures++;
          $display("FAIL toggle_done: done=%b cyc=%0d, expected ch%0d at %0d",
                   done, cyc, e.ch, e.cyc);
        end
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL toggle_hold: busy=%b at cyc %0d, expected 1", busy, cyc);
        end
      end
      enable = ~enable;
    end
    enable = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL toggle_timeout: missing=%0d, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_abort;
    exp_t e;
    int   acc;
    apply_reset();
    req_interval[0*W +: W] = 8'd3;
    req_interval[3*W +: W] = 8'd2;
    req_valid = 4'b0001;
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 4'b1000;
    push_exp(3, acc + 7);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (busy !== 1'b1 || active_ch !== 2'd0 || req_ready[3] !== 1'b0) begin
      failures++;
      $display("FAIL abort_setup: busy=%b act=%0d ready3=%b, expected 1 0 0",
               busy, active_ch, req_ready[3]);
    end
    repeat (2) @(negedge clk);
    abort = 4'b0001;
    @(negedge clk);
    abort = '0;
    checks++;
    if (done !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone: done=%b busy=%b, expected 0000 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || active_ch !== 2'd3 || done !== 4'b0) begin
      failures++;
      $display("FAIL abort_next_grant: busy=%b act=%0d done=%b, expected 1 3 0000",
               busy, active_ch, done);
    end
    for (int t = 0; t < 20 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++;
        if (done !== (4'b0001 << e.ch) || cyc != e.cyc) begin
          failures++;
          $display("FAIL abort_ch3_done: done=%b cyc=%0d, expected ch%0d at %0d",
                   done, cyc, e.ch, e.cyc);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL abort_timeout: missing=%0d, expected 0", sb.size());
      sb.delete();
    end
    // Abort in the same cycle as a post discards the post.
    req_interval[2*W +: W] = 8'd2;
    req_valid = 4'b0100;
    abort = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    abort = '0;
    checks++;
    if (req_ready[2] !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_vs_accept: ready2=%b busy=%b, expected 1 0", req_ready[2], busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 4'b0) begin
      failures++;
      $display("FAIL abort_vs_accept_idle: busy=%b done=%b, expected 0 0000", busy, done);
    end
  endtask

  task automatic test_zero_interval;
    exp_t e;
    int   acc;
    apply_reset();
    req_interval[3*W +: W] = 8'd0;
    req_valid = 4'b1000;
    acc = cyc + 1;
    push_exp(3, acc + 2);
    @(negedge clk);
    req_valid = '0;
    for (int t = 0; t < 20 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++;
        if (done !== (4'b0001 << e.ch) || cyc != e.cyc) begin
          failures++;
          $display("FAIL zero_done: done=%b cyc=%0d, expected ch%0d at %0d",
                   done, cyc, e.ch, e.cyc);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL zero_timeout: missing=%0d, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   acc;
    bit   reposted;
    apply_reset();
    req_interval[0*W +: W] = 8'd2;
    req_interval[1*W +: W] = 8'd2;
    req_valid = 4'b0011;
    acc = cyc + 1;
    push_exp(0, acc + 3);
    push_exp(1, acc + 6);
    reposted = 1'b0;
    @(negedge clk);
    req_valid = '0;
    for (int t = 0; t < 40 && sb.size() > 0; t++) begin
      @(negedge clk);
      req_valid = '0;
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++;
        if (done !== (4'b0001 << e.ch) || cyc != e.cyc) begin
          failures++;
          $display("FAIL b2b_done: done=%b cyc=%0d, expected ch%0d at %0d",
                   done, cyc, e.ch, e.cyc);
        end
        if (e.ch == 0 && !reposted) begin
          // Owner re-posts in its done cycle and queues behind channel 1.
          reposted = 1'b1;
          req_interval[0*W +: W] = 8'd1;
          req_valid = 4'b0001;
          push_exp(0, cyc + 5);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_timeout: missing=%0d, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_count;
    exp_t e;
    int   acc;
    apply_reset();
    req_interval[1*W +: W] = 8'd10;
    req_interval[2*W +: W] = 8'd7;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (busy !== 1'b1 || active_ch !== 2'd1 || req_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL midrst_setup: busy=%b act=%0d ready2=%b, expected 1 1 0",
               busy, active_ch, req_ready[2]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 4'b0 || req_ready !== 4'hF || active_ch !== 2'd0) begin
      failures++;
      $display("FAIL midrst_clear: busy=%b done=%b ready=%b act=%0d, expected 0 0000 1111 0",
               busy, done, req_ready, active_ch);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // Channel 1 wins over channel 2 only if priority restarted at channel 0.
    req_interval[1*W +: W] = 8'd2;
    req_interval[2*W +: W] = 8'd2;
    req_valid = 4'b0110;
    acc = cyc + 1;
    push_exp(1, acc + 3);
    push_exp(2, acc + 6);
    @(negedge clk);
    req_valid = '0;
    for (int t = 0; t < 30 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++;
        if (done !== (4'b0001 << e.ch) || cyc != e.cyc) begin
          failures++;
          $display("FAIL midrst_after: done=%b cyc=%0d, expected ch%0d at %0d",
                   done, cyc, e.ch, e.cyc);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL midrst_timeout: missing=%0d, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_channels();
    test_enable_toggle();
    test_abort();
    test_zero_interval();
    test_back_to_back();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
